// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - sweeps all 2^N_IN vectors into a function under test and checks each against a golden table
// Optional build macro: TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN (end the sweep at the first mismatch)
module truth_table_checker #(
  parameter int                   N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 8'b0011_0001,
  parameter int                   SETTLE = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic            ffv_q, ffv_d;
  logic            mismatch;

  // State and sweep bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffvec_q <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffvec_q <= ffvec_d;
      ffv_q   <= ffv_d;
    end
  end

  // Next-state logic: settle each vector, then compare against the golden bit
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ffvec_d  = ffvec_q;
    ffv_d    = ffv_q;
    // Case inequality so an undriven or X response is never taken as a match
    mismatch = (dut_y !== EXPECT[vec_q]);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ffvec_d = '0;
          ffv_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffvec_d = vec_q;
            ffv_d   = 1'b1;
          end
        end
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
        if (mismatch || vec_q == VEC_LAST) begin
`else
        if (vec_q == VEC_LAST) begin
`endif
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The vector register drives the DUT directly, so it holds the last (or failing) vector in DONE
  assign dut_in           = vec_q;
  assign busy             = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (err_q == '0);
  assign fail             = done && (err_q != '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - directed-vector bench for truth_table_checker
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start2;
  logic [2:0] dut_in;
  logic       dut_y, busy, done, pass, fail, ffv;
  logic [3:0] err;
  logic [2:0] ffvec;
  logic [1:0] dut2_in;
  logic       dut2_y, busy2, done2, pass2, fail2, ffv2;
  logic [2:0] err2;
  logic [1:0] ffvec2;

  int mode, mode2;
  int total, bad;

  logic good;
  // Reference function y=1 for 000, 100, 101 written independently of the golden table
  always_comb begin
    good  = ~dut_in[1] & (dut_in[2] | ~dut_in[0]);
    dut_y = good;
    case (mode)
      1:       dut_y = 1'b0;
      2:       dut_y = ~good;
      3:       dut_y = (dut_in == 3'd5) ? ~good : good;
      default: dut_y = good;
    endcase
  end

  assign dut2_y = (mode2 == 1) ? (dut2_in[1] | dut2_in[0]) : (dut2_in[1] & dut2_in[0]);

  truth_table_checker u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_in(dut_in), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .err_count(err),
    .first_fail_vec(ffvec), .first_fail_valid(ffv)
  );

  truth_table_checker #(.N_IN(2), .EXPECT(4'b1000), .SETTLE(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .dut_in(dut2_in), .dut_y(dut2_y),
    .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .err_count(err2),
    .first_fail_vec(ffvec2), .first_fail_valid(ffv2)
  );

  task automatic run_sweep(input int which, output int edges);
    @(negedge clk);
    if (which == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    edges = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if ((which == 0 && done) || (which == 1 && done2)) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy, done, pass, fail, ffv} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {busy, done, pass, fail, ffv}); end
    total++; if ({err, ffvec, dut_in} !== 10'b0) begin bad++; $display("FAIL reset_regs got=%h want=0", {err, ffvec, dut_in}); end
    total++; if ({busy2, done2, pass2, fail2, ffv2, err2, ffvec2, dut2_in} !== 12'b0) begin bad++; $display("FAIL reset_inst2 got=%h want=0", {busy2, done2, pass2, fail2, ffv2, err2, ffvec2, dut2_in}); end
    reset = 1'b0;
  endtask

  task automatic test_pass;
    int e;
    mode = 0;
    run_sweep(0, e);
    total++; if (e !== 24) begin bad++; $display("FAIL pass_latency got=%0d want=24", e); end
    total++; if ({busy, pass, fail, ffv} !== 4'b0100) begin bad++; $display("FAIL pass_flags got=%b want=0100", {busy, pass, fail, ffv}); end
    total++; if (err !== 4'd0) begin bad++; $display("FAIL pass_err got=%0d want=0", err); end
    total++; if (dut_in !== 3'd7) begin bad++; $display("FAIL pass_dut_in got=%0d want=7", dut_in); end
  endtask

  task automatic test_tied_zero;
    int e;
    mode = 1;
    run_sweep(0, e);
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
    total++; if (e !== 3) begin bad++; $display("FAIL tied0_latency got=%0d want=3", e); end
    total++; if (err !== 4'd1) begin bad++; $display("FAIL tied0_err got=%0d want=1", err); end
`else
    total++; if (e !== 24) begin bad++; $display("FAIL tied0_latency got=%0d want=24", e); end
    total++; if (err !== 4'd3) begin bad++; $display("FAIL tied0_err got=%0d want=3", err); end
`endif
    total++; if (ffvec !== 3'd0 || ffv !== 1'b1) begin bad++; $display("FAIL tied0_first got=%0d/%b want=0/1", ffvec, ffv); end
    total++; if ({pass, fail} !== 2'b01) begin bad++; $display("FAIL tied0_passfail got=%b want=01", {pass, fail}); end
  endtask

  task automatic test_inverted_then_good;
    int e;
    mode = 2;
    run_sweep(0, e);
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
    total++; if (err !== 4'd1) begin bad++; $display("FAIL inv_err got=%0d want=1", err); end
`else
    total++; if (err !== 4'd8) begin bad++; $display("FAIL inv_err got=%0d want=8", err); end
`endif
    total++; if (ffvec !== 3'd0 || {pass, fail} !== 2'b01) begin bad++; $display("FAIL inv_first got=%0d/%b want=0/01", ffvec, {pass, fail}); end
    mode = 0;
    run_sweep(0, e);
    total++; if (e !== 24 || {pass, fail, ffv} !== 3'b100 || err !== 4'd0) begin bad++; $display("FAIL restart_good got=%0d/%b/%0d want=24/100/0", e, {pass, fail, ffv}, err); end
  endtask

  task automatic test_start_ignored_and_reset;
    int e;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    e = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      start = (n == 5 || n == 12);
      if (n == 1) begin
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL busy_during got=%b%b want=10", busy, done); end
      end
      if (done) begin e = n; break; end
    end
    start = 1'b0;
    total++; if (e !== 24 || pass !== 1'b1) begin bad++; $display("FAIL restart_ignored got=%0d/%b want=24/1", e, pass); end
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (dut_in == 3'd3) break;
      @(posedge clk); #1;
    end
    total++; if (dut_in !== 3'd3 || err !== 4'd1) begin bad++; $display("FAIL pre_reset got=%0d/%0d want=3/1", dut_in, err); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if ({busy, done, pass, fail, ffv, err, ffvec, dut_in} !== 15'b0) begin bad++; $display("FAIL midsweep_reset got=%h want=0", {busy, done, pass, fail, ffv, err, ffvec, dut_in}); end
    mode = 0;
    run_sweep(0, e);
    total++; if (e !== 24 || pass !== 1'b1 || err !== 4'd0) begin bad++; $display("FAIL after_reset got=%0d/%b/%0d want=24/1/0", e, pass, err); end
  endtask

  task automatic test_two_input;
    int e;
    mode2 = 0;
    run_sweep(1, e);
    total++; if (e !== 8 || {pass2, fail2} !== 2'b10) begin bad++; $display("FAIL and_gate got=%0d/%b want=8/10", e, {pass2, fail2}); end
    mode2 = 1;
    run_sweep(1, e);
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
    total++; if (e !== 4 || err2 !== 3'd1) begin bad++; $display("FAIL or_gate got=%0d/%0d want=4/1", e, err2); end
`else
    total++; if (e !== 8 || err2 !== 3'd2) begin bad++; $display("FAIL or_gate got=%0d/%0d want=8/2", e, err2); end
`endif
    total++; if (ffvec2 !== 2'd1 || {pass2, fail2} !== 2'b01) begin bad++; $display("FAIL or_first got=%0d/%b want=1/01", ffvec2, {pass2, fail2}); end
  endtask

  task automatic test_single_fault;
    int e;
    mode = 3;
    run_sweep(0, e);
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
    total++; if (e !== 18 || dut_in !== 3'd5) begin bad++; $display("FAIL stop_at5 got=%0d/%0d want=18/5", e, dut_in); end
`else
    total++; if (e !== 24 || dut_in !== 3'd7) begin bad++; $display("FAIL fault5 got=%0d/%0d want=24/7", e, dut_in); end
`endif
    total++; if (err !== 4'd1 || ffvec !== 3'd5 || fail !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL fault5_result got=%0d/%0d/%b%b want=1/5/01", err, ffvec, pass, fail); end
  endtask

  initial begin
    total = 0; bad = 0;
    mode = 0; mode2 = 0;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    test_reset();
    test_pass();
    test_tied_zero();
    test_inverted_then_good();
    test_start_ignored_and_reset();
    test_two_input();
    test_single_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Hardware self-checking engine for any N-input, 1-output combinational function.
- Sweeps all 2^N_IN input vectors into an external DUT, waits a settle time, and compares the DUT output with a golden truth table held in a parameter.
- Counts mismatches, records the first failing vector, and drives done/pass/fail flags suitable for board LEDs.
- Sits between the board top level and the function under test; replaces the simulation-only initial-block checking with synthesizable logic.

Parameters:
- N_IN, 3, number of DUT inputs (1..8).
- EXPECT, 8'b0011_0001, golden truth table, 2^N_IN bits; bit i = expected y for input vector i. The default encodes y=1 for 000, 100, 101.
- SETTLE, 2, cycles the DUT inputs are held before sampling (minimum 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- dut_in  output  N_IN  vector applied to the DUT.
- dut_y  input  1  DUT response.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until restart or reset.
- pass  output  1  done and zero mismatches.
- fail  output  1  done and at least one mismatch.
- err_count  output  N_IN+1  number of mismatching vectors.
- first_fail_vec  output  N_IN  first mismatching vector.
- first_fail_valid  output  1  first_fail_vec holds a valid vector.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset, including mid-sweep: state goes to IDLE; all outputs and internal counters go to 0 on the next edge.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE: start=1 → vec<=0, dut_in<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, settle cnt<=0, done/pass/fail<=0, go to WAIT.
- WAIT: busy=1. Increment cnt each cycle. When cnt==SETTLE-1, go to CHECK.
- CHECK: busy=1. Compare dut_y with EXPECT[vec] using case equality; X or Z on dut_y counts as a mismatch in simulation.
  - On mismatch: err_count++. If first_fail_valid=0, set first_fail_vec<=vec and first_fail_valid<=1.
  - If vec==2^N_IN-1 → DONE.
  - Otherwise vec++, dut_in<=vec+1, cnt<=0, go to WAIT.
- Timing: each vector takes SETTLE+1 cycles. done rises 2^N_IN*(SETTLE+1) edges after the start edge (24 with defaults).
- DONE: busy=0, done=1, pass=(err_count==0), fail=(err_count!=0). dut_in holds the last vector. All outputs hold until start or reset. start=1 restarts the sweep exactly as from IDLE.
- start while busy is ignored; timing is unchanged.
- err_count is N_IN+1 bits wide and cannot overflow (maximum 2^N_IN).
- pass and fail are never both 1. Both are 0 whenever done=0.

Optional Feature:
- Macro: TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE.
  - err_count=1 and fail=1.
  - dut_in and first_fail_vec both hold the failing vector, so it can be read on LEDs.
- Undefined: the full sweep always completes as described above.

Test Plan:
1. Defaults, DUT implements EXPECT, start pulsed → done=1 after 24 cycles, pass=1, fail=0, err_count=0, first_fail_valid=0.
2. Defaults, dut_y tied 0 → mismatches on vectors 0, 4, 5 → err_count=3, first_fail_vec=0, first_fail_valid=1, fail=1, pass=0.
3. Defaults, DUT outputs the inverted function → err_count=8, first_fail_vec=0, fail=1. Restart with a correct DUT → pass=1, err_count=0.
4. start re-pulsed at cycles 5 and 12 of a sweep → ignored, done still rises at cycle 24. reset asserted while vec=3 → next edge: IDLE, all outputs 0. A fresh start then completes normally.
5. N_IN=2, EXPECT=4'b1000, SETTLE=1, DUT = AND gate → done after 8 cycles, pass=1. Swap in an OR gate → err_count=2, first_fail_vec=1.
6. STOP_ON_FAIL_EN defined, defaults, DUT wrong only at vector 101 → done after 18 cycles, err_count=1, first_fail_vec=5, dut_in=5, fail=1.
